ga21_pal_dma: RTL and testbench

//  Palette DMA/access sequencer feeding the palette RAM stage. Copies a block of
//  16-bit colour words from the CPU-side palette buffer into palette RAM during

---
 rtl/ga21_pal_dma_pkg.sv | 16 +
 rtl/ga21_dma_addrgen.sv | 63 ++++++
 rtl/ga21_pal_dma.sv | 152 +++++++++++++++
 tb/tb_ga21_pal_dma.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ga21_pal_dma_pkg.sv
// Shared types and widths for the palette DMA sequencer.
// Palette RAM is 8K x 16-bit colour words.
package ga21_pal_dma_pkg;

  localparam int PAL_AW = 13;
  localparam int COL_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_FLUSH = 3'd4
  } dma_state_e;

endpackage

// File: rtl/ga21_dma_addrgen.sv
// Source/destination pointer and remaining-count generator for the palette DMA.
// Source advances per read issued, destination per word written; both wrap naturally.
module ga21_dma_addrgen
  import ga21_pal_dma_pkg::*;
#(
  parameter int SRC_AW = 13,
  parameter int LEN_W  = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [SRC_AW-1:0] src_base,
  input  logic [PAL_AW-1:0] dst_base,
  input  logic [LEN_W-1:0]  len,
  input  logic              rd_adv,
  input  logic              wr_adv,
  output logic [SRC_AW-1:0] src_ptr,
  output logic [PAL_AW-1:0] dst_ptr,
  output logic              last
);

  logic [SRC_AW-1:0] src_q, src_d;
  logic [PAL_AW-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]  rem_q, rem_d;

  // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
  always_comb begin
    src_d = src_q;
    dst_d = dst_q;
    rem_d = rem_q;
    if (load) begin
      src_d = src_base;
      dst_d = dst_base;
      rem_d = len;
    end else begin
      if (rd_adv) begin
        src_d = src_q + SRC_AW'(1);
        rem_d = rem_q - LEN_W'(1);
      end
      if (wr_adv) begin
        dst_d = dst_q + PAL_AW'(1);
      end
    end
  end

  // NOTE: non-blocking assignments so all flops update together from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_q <= '0;
      dst_q <= '0;
      rem_q <= '0;
    end else begin
      src_q <= src_d;
      dst_q <= dst_d;
      rem_q <= rem_d;
    end
  end

  assign src_ptr = src_q;
  assign dst_ptr = dst_q;
  assign last    = (rem_q == LEN_W'(1));

endmodule

// File: rtl/ga21_pal_dma.sv
// Palette DMA sequencer: copies a source block into palette RAM during vblank
// and arbitrates direct CPU palette accesses around the DMA write slots.
module ga21_pal_dma
  import ga21_pal_dma_pkg::*;
#(
  parameter int SRC_AW = 13,
  parameter int LEN_W  = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vblank,
  input  logic              dma_start,
  input  logic [SRC_AW-1:0] dma_src_base,
  input  logic [PAL_AW-1:0] dma_dst_base,
  input  logic [LEN_W-1:0]  dma_len,
  output logic [SRC_AW-1:0] src_addr,
  input  logic [COL_W-1:0]  src_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [COL_W-1:0]  cpu_wdata,
  output logic              cpu_ack,
  output logic              dma_busy,
  output logic [PAL_AW-1:0] ga21_addr,
  output logic              ga21_we,
  output logic              ga21_req,
  output logic [COL_W-1:0]  pal_wdata,
  output logic              dma_pending,
  output logic              dma_done
);

  dma_state_e state_q, state_d;
  logic             inflight_q, inflight_d;
  logic [COL_W-1:0] hold_q, hold_d;
  logic             hold_vld_q, hold_vld_d;
  logic             done_q, done_d;
  logic             pending_q, pending_d;

  logic              load;
  logic              rd_issue;
  logic              dma_wr;
  logic [COL_W-1:0]  dma_wdata;
  logic              cpu_grant;
  logic [SRC_AW-1:0] src_ptr;
  logic [PAL_AW-1:0] dst_ptr;
  logic              rem_last;

  ga21_dma_addrgen #(
    .SRC_AW(SRC_AW),
    .LEN_W (LEN_W)
  ) u_addrgen (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .src_base(dma_src_base),
    .dst_base(dma_dst_base),
    .len     (dma_len),
    .rd_adv  (rd_issue),
    .wr_adv  (dma_wr),
    .src_ptr (src_ptr),
    .dst_ptr (dst_ptr),
    .last    (rem_last)
  );

  always_comb begin
    state_d    = state_q;
    inflight_d = 1'b0;
    hold_d     = hold_q;
    hold_vld_d = 1'b0;
    done_d     = 1'b0;
    load       = 1'b0;
    rd_issue   = 1'b0;
    dma_wr     = 1'b0;
    dma_wdata  = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (dma_start) begin
          if (dma_len != '0) begin
            load    = 1'b1;
            state_d = ST_ARMED;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_ARMED: begin
        if (vblank) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (vblank) begin
          rd_issue   = 1'b1;
          inflight_d = 1'b1;
          dma_wr     = inflight_q;
          dma_wdata  = src_data;
          if (rem_last) state_d = ST_FLUSH;
        end else begin
          // Park the in-flight word; it is written in DRAIN, not lost or re-read.
          hold_d     = src_data;
          hold_vld_d = inflight_q;
          state_d    = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        dma_wr    = hold_vld_q;
        dma_wdata = hold_q;
        state_d   = ST_ARMED;
      end
      ST_FLUSH: begin
        dma_wr    = 1'b1;
        dma_wdata = src_data;
        done_d    = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Pending stays up through the cycle the real transfer reports done.
    pending_d = (state_d != ST_IDLE) || (state_q == ST_FLUSH);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      inflight_q <= 1'b0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      done_q     <= 1'b0;
      pending_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      done_q     <= done_d;
      pending_q  <= pending_d;
    end
  end

  // CPU is held off for the whole RUN phase and in any DMA write slot.
  assign cpu_grant = cpu_req && !dma_wr && (state_q != ST_RUN);

  assign src_addr    = src_ptr;
  assign dma_busy    = dma_wr;
  assign ga21_addr   = dma_wr ? dst_ptr : '0;
  assign ga21_we     = dma_wr || (cpu_grant && cpu_we);
  assign ga21_req    = cpu_grant;
  assign cpu_ack     = cpu_grant;
  assign pal_wdata   = dma_wr ? dma_wdata : (cpu_grant ? cpu_wdata : '0);
  assign dma_pending = pending_q;
  assign dma_done    = done_q;

endmodule

// File: tb/tb_ga21_pal_dma.sv
// Scoreboard bench for ga21_pal_dma: a block-copy model queues the expected
// palette writes; a monitor pops and compares them as the DUT writes.
module tb_ga21_pal_dma;

  localparam int SRC_AW = 13;
  localparam int LEN_W  = 12;
  localparam int MEMW   = 8192;

  logic              clk = 1'b0;
  logic              reset;
  logic              vblank;
  logic              dma_start;
  logic [SRC_AW-1:0] dma_src_base;
  logic [12:0]       dma_dst_base;
  logic [LEN_W-1:0]  dma_len;
  logic [SRC_AW-1:0] src_addr;
  logic [15:0]       src_data;
  logic              cpu_req;
  logic              cpu_we;
  logic [15:0]       cpu_wdata;
  logic              cpu_ack;
  logic              dma_busy;
  logic [12:0]       ga21_addr;
  logic              ga21_we;
  logic              ga21_req;
  logic [15:0]       pal_wdata;
  logic              dma_pending;
  logic              dma_done;

  ga21_pal_dma #(.SRC_AW(SRC_AW), .LEN_W(LEN_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .vblank      (vblank),
    .dma_start   (dma_start),
    .dma_src_base(dma_src_base),
    .dma_dst_base(dma_dst_base),
    .dma_len     (dma_len),
    .src_addr    (src_addr),
    .src_data    (src_data),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_wdata   (cpu_wdata),
    .cpu_ack     (cpu_ack),
    .dma_busy    (dma_busy),
    .ga21_addr   (ga21_addr),
    .ga21_we     (ga21_we),
    .ga21_req    (ga21_req),
    .pal_wdata   (pal_wdata),
    .dma_pending (dma_pending),
    .dma_done    (dma_done)
  );

  always #5 clk = ~clk;

  // Source buffer with one-cycle synchronous read.
  logic [15:0] src_mem [MEMW];
  always @(posedge clk) src_data <= src_mem[src_addr];

  typedef struct packed {
    logic [12:0] addr;
    logic [15:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  wr_cyc_q[$];
  wr_t mon_e;
  int  tests = 0;
  int  fails = 0;
  int  cyc = 0;
  int  done_cnt = 0;
  int  done_cyc = 0;
  int  pend_at_done = 0;
  int  ack_cnt = 0;
  int  ack_cyc = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare every DMA write and CPU access against the model.
  always @(negedge clk) begin
    if (!reset) begin
      if (dma_busy && ga21_req) begin
        tests++;
        fails++;
        $display("FAIL busy_req_overlap: both high at cycle %0d", cyc);
      end
      if (dma_busy) begin
        wr_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected", ga21_addr, pal_wdata);
        end else begin
          mon_e = exp_q.pop_front();
          check("wr_addr", 32'(ga21_addr), 32'(mon_e.addr));
          check("wr_data", 32'(pal_wdata), 32'(mon_e.data));
          check("wr_we", 32'(ga21_we), 32'd1);
        end
      end
      if (dma_done) begin
        done_cnt++;
        done_cyc = cyc;
        pend_at_done = int'(dma_pending);
      end
      if (cpu_ack) begin
        ack_cnt++;
        ack_cyc = cyc;
        check("ack_req", 32'(ga21_req), 32'd1);
        check("ack_we", 32'(ga21_we), 32'(cpu_we));
        check("ack_data", 32'(pal_wdata), 32'(cpu_wdata));
        check("ack_busy", 32'(dma_busy), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse dma_start; when the model expects acceptance, queue the block copy.
  task automatic start_xfer(input logic [12:0] s, input logic [12:0] d, input int l, input bit accept);
    dma_src_base = s;
    dma_dst_base = d;
    dma_len      = LEN_W'(l);
    dma_start    = 1'b1;
    if (accept) begin
      for (int i = 0; i < l; i++)
        exp_q.push_back('{addr: 13'((int'(d) + i) % MEMW), data: src_mem[(int'(s) + i) % MEMW]});
    end
    tick();
    dma_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rand_vb);
    int c0;
    int n;
    c0 = done_cnt;
    n  = 0;
    while (done_cnt == c0 && n < budget) begin
      if (rand_vb) vblank = ($urandom_range(0, 3) != 0);
      tick();
      n++;
    end
    check("done_seen", 32'(done_cnt - c0), 32'd1);
    check("done_pending", 32'(pend_at_done), 32'd1);
    check("done_one_cycle", 32'(dma_done), 32'd0);
    check("pending_clear", 32'(dma_pending), 32'd0);
    check("all_words_written", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, 32'(dma_busy), 32'd0);
    check({tag, "_we"}, 32'(ga21_we), 32'd0);
    check({tag, "_req"}, 32'(ga21_req), 32'd0);
    check({tag, "_ack"}, 32'(cpu_ack), 32'd0);
    check({tag, "_addr"}, 32'(ga21_addr), 32'd0);
    check({tag, "_wdata"}, 32'(pal_wdata), 32'd0);
    check({tag, "_src"}, 32'(src_addr), 32'd0);
    check({tag, "_pending"}, 32'(dma_pending), 32'd0);
    check({tag, "_done"}, 32'(dma_done), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int a0;
    int n;
    int l;
    for (int i = 0; i < MEMW; i++) src_mem[i] = 16'($urandom);
    reset = 1'b1;
    vblank = 1'b0;
    dma_start = 1'b0;
    dma_src_base = '0;
    dma_dst_base = '0;
    dma_len = '0;
    cpu_req = 1'b0;
    cpu_we = 1'b0;
    cpu_wdata = '0;
    repeat (3) tick();
    check_outputs_zero("reset");
    reset = 1'b0;
    tick();

    // Block copy across the palette wrap, vblank held high.
    vblank = 1'b1;
    wr_cyc_q.delete();
    start_xfer(13'h010, 13'h1FFE, 4, 1'b1);
    check("t1_pending", 32'(dma_pending), 32'd1);
    wait_done(50, 1'b0);
    check("t1_nwrites", 32'(wr_cyc_q.size()), 32'd4);
    if (wr_cyc_q.size() == 4) begin
      for (int i = 1; i < 4; i++) check("t1_consecutive", 32'(wr_cyc_q[i] - wr_cyc_q[i-1]), 32'd1);
      check("t1_done_timing", 32'(done_cyc), 32'(wr_cyc_q[3] + 1));
    end

    // Pause after the second read; resume on the next vblank.
    wr_cyc_q.delete();
    start_xfer(13'h1FFC, 13'h0100, 6, 1'b1);
    repeat (3) tick();
    vblank = 1'b0;
    repeat (5) tick();
    check("t2_paused_writes", 32'(wr_cyc_q.size()), 32'd2);
    check("t2_remaining", 32'(exp_q.size()), 32'd4);
    vblank = 1'b1;
    wait_done(50, 1'b0);
    check("t2_total_writes", 32'(wr_cyc_q.size()), 32'd6);

    // CPU request held across a RUN burst.
    wr_cyc_q.delete();
    c0 = done_cnt;
    a0 = ack_cnt;
    start_xfer(13'h0400, 13'h0800, 8, 1'b1);
    repeat (2) tick();
    cpu_req = 1'b1;
    cpu_we = 1'b1;
    cpu_wdata = 16'($urandom);
    n = 0;
    while (ack_cnt == a0 && n < 60) begin
      tick();
      n++;
    end
    cpu_req = 1'b0;
    check("t3_ack_seen", 32'(ack_cnt - a0), 32'd1);
    check("t3_dma_complete", 32'(exp_q.size()), 32'd0);
    check("t3_writes", 32'(wr_cyc_q.size()), 32'd8);
    if (wr_cyc_q.size() == 8) check("t3_ack_after_last", 32'(ack_cyc), 32'(wr_cyc_q[7] + 1));
    check("t3_done", 32'(done_cnt - c0), 32'd1);
    tick();

    // CPU read while idle.
    a0 = ack_cnt;
    cpu_req = 1'b1;
    cpu_we = 1'b0;
    cpu_wdata = 16'($urandom);
    tick();
    cpu_req = 1'b0;
    check("t3_idle_ack", 32'(ack_cnt - a0), 32'd1);

    // Zero-length start: done next cycle, nothing written, never pending.
    wr_cyc_q.delete();
    c0 = done_cnt;
    start_xfer(13'h0123, 13'h0456, 0, 1'b0);
    check("t4_done_pulse", 32'(dma_done), 32'd1);
    check("t4_pending", 32'(dma_pending), 32'd0);
    tick();
    check("t4_done_once", 32'(done_cnt - c0), 32'd1);
    check("t4_done_low", 32'(dma_done), 32'd0);
    check("t4_no_writes", 32'(wr_cyc_q.size()), 32'd0);

    // Start while vblank low, then a second start that must be ignored.
    vblank = 1'b0;
    start_xfer(13'h0200, 13'h0300, 3, 1'b1);
    start_xfer(13'h0900, 13'h0A00, 5, 1'b0);
    repeat (6) tick();
    check("t4_armed_pending", 32'(dma_pending), 32'd1);
    check("t4_armed_no_writes", 32'(wr_cyc_q.size()), 32'd0);
    vblank = 1'b1;
    wait_done(50, 1'b0);
    check("t4_orig_cfg_writes", 32'(wr_cyc_q.size()), 32'd3);

    // Asynchronous reset in the middle of RUN.
    c0 = done_cnt;
    start_xfer(13'h0500, 13'h0600, 10, 1'b1);
    repeat (4) tick();
    reset = 1'b1;
    #1;
    check_outputs_zero("midrun_reset");
    exp_q.delete();
    repeat (2) tick();
    reset = 1'b0;
    repeat (5) tick();
    check("t5_no_done", 32'(done_cnt - c0), 32'd0);
    wr_cyc_q.delete();
    start_xfer(13'h0700, 13'h0010, 2, 1'b1);
    wait_done(50, 1'b0);
    check("t5_writes", 32'(wr_cyc_q.size()), 32'd2);

    // Random transfers with random vblank gaps.
    for (int t = 0; t < 30; t++) begin
      l = $urandom_range(1, 24);
      vblank = ($urandom_range(0, 1) != 0);
      start_xfer(13'($urandom), 13'($urandom), l, 1'b1);
      wait_done(400, 1'b1);
      vblank = 1'b0;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
